uart_cmd_ctrl: RTL and testbench

//  Frame controller behind uart_rx. Converts the byte stream (rx_rdy/rx_data) into fixed 5-byte commands:
//  HDR, OP, ARG_H, ARG_L, CHK, where CHK = OP ^ ARG_H ^ ARG_L.

---
 rtl/uart_cmd_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Frame controller behind uart_rx: assembles HDR/OP/ARG_H/ARG_L/CHK byte frames
// into valid/ack commands, with resync, checksum, timeout and overrun reporting.
module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER  = 8'hAA,
    parameter int         TIMEOUT = 50000,
    parameter int         TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_arg,
    input  logic        cmd_ack,
    output logic        err_chk,
    output logic        err_to,
    output logic        err_ovr,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {S_HDR, S_OP, S_ARGH, S_ARGL, S_CHK} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            rx_rdy_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      op_buf_q, op_buf_d;
    logic [7:0]      argh_buf_q, argh_buf_d;
    logic [7:0]      argl_buf_q, argl_buf_d;
    logic [7:0]      chk_acc_q, chk_acc_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      cmd_op_q, cmd_op_d;
    logic [15:0]     cmd_arg_q, cmd_arg_d;
    logic            err_chk_q, err_chk_d;
    logic            err_to_q, err_to_d;
    logic            err_ovr_q, err_ovr_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            byte_stb;

    // rx_rdy is a level held for many cycles; only its rising edge counts as a byte.
    assign byte_stb = rx_rdy & ~rx_rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR;
            rx_rdy_q    <= 1'b0;
            to_cnt_q    <= '0;
            op_buf_q    <= '0;
            argh_buf_q  <= '0;
            argl_buf_q  <= '0;
            chk_acc_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_arg_q   <= '0;
            err_chk_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_ovr_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rx_rdy_q    <= rx_rdy;
            to_cnt_q    <= to_cnt_d;
            op_buf_q    <= op_buf_d;
            argh_buf_q  <= argh_buf_d;
            argl_buf_q  <= argl_buf_d;
            chk_acc_q   <= chk_acc_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_arg_q   <= cmd_arg_d;
            err_chk_q   <= err_chk_d;
            err_to_q    <= err_to_d;
            err_ovr_q   <= err_ovr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        op_buf_d    = op_buf_q;
        argh_buf_d  = argh_buf_q;
        argl_buf_d  = argl_buf_q;
        chk_acc_d   = chk_acc_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_arg_d   = cmd_arg_q;
        err_chk_d   = 1'b0;
        err_to_d    = 1'b0;
        err_ovr_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (cmd_valid_q && cmd_ack)
            cmd_valid_d = 1'b0;

        // Inter-byte timer only runs mid-frame; a strobe always beats expiry.
        if (state_q == S_HDR || byte_stb) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            state_d  = S_HDR;
            err_to_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (byte_stb) begin
            unique case (state_q)
                S_HDR: if (rx_data == HEADER) state_d = S_OP;
                S_OP: begin
                    op_buf_d  = rx_data;
                    chk_acc_d = rx_data;
                    state_d   = S_ARGH;
                end
                S_ARGH: begin
                    argh_buf_d = rx_data;
                    chk_acc_d  = chk_acc_q ^ rx_data;
                    state_d    = S_ARGL;
                end
                S_ARGL: begin
                    argl_buf_d = rx_data;
                    chk_acc_d  = chk_acc_q ^ rx_data;
                    state_d    = S_CHK;
                end
                S_CHK: begin
                    state_d = S_HDR;
                    if (rx_data != chk_acc_q) begin
                        err_chk_d = 1'b1;
                    end else if (!cmd_valid_q || cmd_ack) begin
                        // A same-edge ack frees the slot, so the new command replaces it.
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = op_buf_q;
                        cmd_arg_d   = {argh_buf_q, argl_buf_q};
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        err_ovr_d = 1'b1;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_arg   = cmd_arg_q;
    assign err_chk   = err_chk_q;
    assign err_to    = err_to_q;
    assign err_ovr   = err_ovr_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: good frames, checksum errors, resync,
// timeout, overrun/replace handshake, mid-frame reset and frame counter wrap.
module tb_uart_cmd_ctrl;

    logic        clk, rst, rx_rdy, cmd_ack;
    logic [7:0]  rx_data;
    logic        cmd_valid, err_chk, err_to, err_ovr;
    logic [7:0]  cmd_op, frame_cnt;
    logic [15:0] cmd_arg;

    int checks = 0, passes = 0;
    int cyc = 0, last_stb = 0;
    int n_chk = 0, n_to = 0, n_ovr = 0, n_fall = 0, n_multi = 0;
    int rise_cyc = -1, to_cyc = -1;
    logic prev_valid = 1'b0;

    uart_cmd_ctrl #(.HEADER(8'hAA), .TIMEOUT(100), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_ack(cmd_ack),
        .err_chk(err_chk), .err_to(err_to), .err_ovr(err_ovr), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (err_chk) n_chk <= n_chk + 1;
        if (err_ovr) n_ovr <= n_ovr + 1;
        if (err_to) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (32'(err_chk) + 32'(err_to) + 32'(err_ovr) > 1) n_multi <= n_multi + 1;
        if (cmd_valid && !prev_valid) rise_cyc <= cyc;
        if (!cmd_valid && prev_valid) n_fall <= n_fall + 1;
        prev_valid <= cmd_valid;
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input bit ack_on_stb);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        if (ack_on_stb) cmd_ack = 1'b1;
        @(posedge clk);
        #1;
        last_stb = cyc;
        cmd_ack  = 1'b0;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        rx_rdy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] ah, input logic [7:0] al,
                              input int hold, input bit ack_on_chk);
        send_byte(8'hAA, hold, 0);
        send_byte(op, hold, 0);
        send_byte(ah, hold, 0);
        send_byte(al, hold, 0);
        send_byte(op ^ ah ^ al, hold, ack_on_chk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; cmd_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_op, cmd_arg, err_chk, err_to, err_ovr, frame_cnt} !== 36'd0)
            $display("FAIL reset_outputs got valid=%b op=%h arg=%h errs=%b%b%b cnt=%0d want all 0",
                     cmd_valid, cmd_op, cmd_arg, err_chk, err_to, err_ovr, frame_cnt);
        else passes++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int c0 = n_chk + n_to + n_ovr;
        send_frame(8'h01, 8'h12, 8'h34, 8, 0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h01 || cmd_arg !== 16'h1234)
            $display("FAIL good_cmd got valid=%b op=%h arg=%h want 1/01/1234", cmd_valid, cmd_op, cmd_arg);
        else passes++;
        checks++;
        if (frame_cnt !== 8'd1) $display("FAIL good_cnt got %0d want 1", frame_cnt);
        else passes++;
        checks++;
        if (rise_cyc !== last_stb) $display("FAIL good_latency valid rose at %0d want %0d", rise_cyc, last_stb);
        else passes++;
        checks++;
        if (n_chk + n_to + n_ovr !== c0) $display("FAIL good_noerr got %0d error pulses want 0", n_chk + n_to + n_ovr - c0);
        else passes++;
        do_ack();
        checks++;
        if (cmd_valid !== 1'b0) $display("FAIL ack_clears got valid=%b want 0", cmd_valid);
        else passes++;
    endtask

    task automatic test_chk_err();
        int c0 = n_chk;
        send_byte(8'hAA, 8, 0); send_byte(8'h05, 8, 0); send_byte(8'h00, 8, 0);
        send_byte(8'h00, 8, 0); send_byte(8'h06, 8, 0);
        checks++;
        if (n_chk - c0 !== 1 || cmd_valid !== 1'b0 || frame_cnt !== 8'd1)
            $display("FAIL chk_err got pulses=%0d valid=%b cnt=%0d want 1/0/1", n_chk - c0, cmd_valid, frame_cnt);
        else passes++;
        send_frame(8'h03, 8'hAB, 8'hCD, 8, 0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h03 || cmd_arg !== 16'hABCD || frame_cnt !== 8'd2)
            $display("FAIL chk_recover got valid=%b op=%h arg=%h cnt=%0d want 1/03/abcd/2",
                     cmd_valid, cmd_op, cmd_arg, frame_cnt);
        else passes++;
        do_ack();
    endtask

    task automatic test_resync();
        int c0 = n_chk;
        logic [7:0] seq [7] = '{8'h55, 8'hAA, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h01};
        foreach (seq[i]) send_byte(seq[i], 8, 0);
        checks++;
        if (n_chk - c0 !== 1 || cmd_valid !== 1'b0 || frame_cnt !== 8'd2)
            $display("FAIL resync_err got pulses=%0d valid=%b cnt=%0d want 1/0/2", n_chk - c0, cmd_valid, frame_cnt);
        else passes++;
        send_frame(8'h10, 8'h20, 8'h30, 8, 0);
        checks++;
        if (cmd_op !== 8'h10 || cmd_arg !== 16'h2030 || frame_cnt !== 8'd3)
            $display("FAIL resync_frame got op=%h arg=%h cnt=%0d want 10/2030/3", cmd_op, cmd_arg, frame_cnt);
        else passes++;
        do_ack();
    endtask

    task automatic test_timeout();
        int t0 = n_to;
        int stb07;
        send_byte(8'hAA, 8, 0);
        send_byte(8'h07, 8, 0);
        stb07 = last_stb;
        repeat (120) @(negedge clk);
        checks++;
        if (n_to - t0 !== 1) $display("FAIL to_pulse got %0d pulses want 1", n_to - t0);
        else passes++;
        checks++;
        if (to_cyc - stb07 !== 100) $display("FAIL to_delay got %0d cycles want 100", to_cyc - stb07);
        else passes++;
        send_frame(8'h07, 8'h00, 8'h01, 8, 0);
        checks++;
        if (cmd_op !== 8'h07 || cmd_arg !== 16'h0001 || frame_cnt !== 8'd4)
            $display("FAIL to_recover got op=%h arg=%h cnt=%0d want 07/0001/4", cmd_op, cmd_arg, frame_cnt);
        else passes++;
        repeat (150) @(negedge clk);
        checks++;
        if (n_to - t0 !== 1) $display("FAIL to_idle_hdr got %0d pulses want 1", n_to - t0);
        else passes++;
        do_ack();
    endtask

    task automatic test_back_to_back();
        int o0 = n_ovr;
        int f0;
        send_frame(8'h01, 8'h00, 8'h00, 8, 0);
        send_frame(8'h02, 8'h00, 8'h00, 8, 0);
        checks++;
        if (n_ovr - o0 !== 1 || cmd_valid !== 1'b1 || cmd_op !== 8'h01 || frame_cnt !== 8'd5)
            $display("FAIL ovr_drop got pulses=%0d valid=%b op=%h cnt=%0d want 1/1/01/5",
                     n_ovr - o0, cmd_valid, cmd_op, frame_cnt);
        else passes++;
        f0 = n_fall;
        send_frame(8'h02, 8'h00, 8'h00, 8, 1);
        checks++;
        if (n_ovr - o0 !== 1 || cmd_op !== 8'h02 || frame_cnt !== 8'd6)
            $display("FAIL ovr_replace got pulses=%0d op=%h cnt=%0d want 1/02/6", n_ovr - o0, cmd_op, frame_cnt);
        else passes++;
        checks++;
        if (cmd_valid !== 1'b1 || n_fall !== f0)
            $display("FAIL replace_valid got valid=%b falls=%0d want 1/0", cmd_valid, n_fall - f0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA, 8, 0); send_byte(8'h01, 8, 0); send_byte(8'h02, 8, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, cmd_op, cmd_arg, err_chk, err_to, err_ovr, frame_cnt} !== 36'd0)
            $display("FAIL rst_mid got valid=%b op=%h arg=%h cnt=%0d want all 0", cmd_valid, cmd_op, cmd_arg, frame_cnt);
        else passes++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h11, 8'h22, 8'h44, 8, 0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h11 || cmd_arg !== 16'h2244 || frame_cnt !== 8'd1)
            $display("FAIL rst_recover got valid=%b op=%h arg=%h cnt=%0d want 1/11/2244/1",
                     cmd_valid, cmd_op, cmd_arg, frame_cnt);
        else passes++;
        do_ack();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 254; i++) begin
            send_frame(8'(i), 8'h00, 8'h00, 2, 0);
            do_ack();
        end
        checks++;
        if (frame_cnt !== 8'd255) $display("FAIL wrap_255 got %0d want 255", frame_cnt);
        else passes++;
        send_frame(8'h5A, 8'h00, 8'h00, 2, 0);
        checks++;
        if (frame_cnt !== 8'd0 || cmd_op !== 8'h5A)
            $display("FAIL wrap_0 got cnt=%0d op=%h want 0/5a", frame_cnt, cmd_op);
        else passes++;
        checks++;
        if (n_multi !== 0) $display("FAIL err_exclusive got %0d overlapping cycles want 0", n_multi);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_chk_err();
        test_resync();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
